// File: rtl/pc_btb_predictor.sv
// Fetch-PC generator with flush redirect capture and an optional direct-mapped BTB.
// Define PC_BTB_EN to build the BTB and its 2-bit counter prediction; otherwise fetch is purely sequential.
module pc_btb_predictor #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    BTB_ENTRIES = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_rdy,
    input  logic                  in_stall,
    input  logic                  in_flush_enable,
    input  logic [ADDR_WIDTH-1:0] in_rob_branch_pc,
    input  logic                  in_rob_update_enable,
    input  logic [ADDR_WIDTH-1:0] in_rob_update_pc,
    input  logic                  in_rob_update_taken,
    input  logic [ADDR_WIDTH-1:0] in_rob_update_target,
    output logic                  out_fetcher_enable,
    output logic [ADDR_WIDTH-1:0] out_fetcher_pc,
    output logic                  out_fetcher_pred_taken,
    output logic [ADDR_WIDTH-1:0] out_fetcher_pred_target
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] PRE_RESET_PC = RESET_PC - PC_STEP;

    logic                  flush_pending;
    logic [ADDR_WIDTH-1:0] flush_target;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  look_taken;
    logic [ADDR_WIDTH-1:0] look_target;

    always_comb begin
        next_pc = out_fetcher_pc + PC_STEP;
        if (flush_pending) begin
            next_pc = flush_target;
        end else if (out_fetcher_pred_taken) begin
            next_pc = out_fetcher_pred_target;
        end
    end

`ifdef PC_BTB_EN
    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_W    = ADDR_WIDTH - IDX_BITS - 2;

    logic                  btb_valid  [BTB_ENTRIES];
    logic [1:0]            btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];

    logic [IDX_BITS-1:0] look_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    look_tag;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    assign look_idx    = next_pc[IDX_BITS+1:2];
    assign look_tag    = next_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign upd_idx     = in_rob_update_pc[IDX_BITS+1:2];
    assign upd_tag     = in_rob_update_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign upd_hit     = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    // Lookup reads the arrays before this edge's training write lands.
    assign look_taken  = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag) && btb_ctr[look_idx][1];
    assign look_target = look_taken ? btb_target[look_idx] : '0;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (in_rdy && in_rob_update_enable) begin
            if (upd_hit) begin
                btb_ctr[upd_idx] <= ctr_next(btb_ctr[upd_idx], in_rob_update_taken);
            end else if (in_rob_update_taken) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target carry no reset; they are qualified by the valid bit.
    always_ff @(posedge in_clk) begin
        if (in_rdy && in_rob_update_enable && in_rob_update_taken) begin
            btb_tag[upd_idx]    <= upd_tag;
            btb_target[upd_idx] <= in_rob_update_target;
        end
    end
`else
    localparam int unused_btb_entries = BTB_ENTRIES;
    logic unused_update;

    assign unused_update = ^{in_rob_update_enable, in_rob_update_pc,
                             in_rob_update_taken, in_rob_update_target};
    assign look_taken    = 1'b0;
    assign look_target   = '0;
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_fetcher_enable      <= 1'b0;
            out_fetcher_pc          <= PRE_RESET_PC;
            out_fetcher_pred_taken  <= 1'b0;
            out_fetcher_pred_target <= '0;
            flush_pending           <= 1'b0;
            flush_target            <= '0;
        end else if (in_rdy) begin
            if (in_flush_enable) begin
                flush_pending      <= 1'b1;
                flush_target       <= in_rob_branch_pc;
                out_fetcher_enable <= 1'b0;
            end else if (in_stall) begin
                out_fetcher_enable <= 1'b0;
            end else begin
                out_fetcher_enable      <= 1'b1;
                out_fetcher_pc          <= next_pc;
                out_fetcher_pred_taken  <= look_taken;
                out_fetcher_pred_target <= look_target;
                flush_pending           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_btb_predictor.sv
// Directed self-checking bench for pc_btb_predictor; expectations follow PC_BTB_EN.
module tb_pc_btb_predictor;

`ifdef PC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        stall;
    logic        flush;
    logic [31:0] branch_pc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        fetch_en;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int checks = 0;
    int errors = 0;

    pc_btb_predictor #(
        .ADDR_WIDTH (32),
        .BTB_ENTRIES(16),
        .RESET_PC   (32'h0)
    ) dut (
        .in_clk                 (clk),
        .in_rst_n               (rst_n),
        .in_rdy                 (rdy),
        .in_stall               (stall),
        .in_flush_enable        (flush),
        .in_rob_branch_pc       (branch_pc),
        .in_rob_update_enable   (upd_en),
        .in_rob_update_pc       (upd_pc),
        .in_rob_update_taken    (upd_taken),
        .in_rob_update_target   (upd_target),
        .out_fetcher_enable     (fetch_en),
        .out_fetcher_pc         (fetch_pc),
        .out_fetcher_pred_taken (pred_taken),
        .out_fetcher_pred_target(pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; stall = 1'b0; flush = 1'b0; branch_pc = '0;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        step();
        step();
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", fetch_en); end
        checks++; if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc got %h exp fffffffc", fetch_pc); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pt got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_ptgt got %h exp 0", pred_target); end
    endtask

    task automatic test_sequential();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL seq_en[%0d] got %b exp 1", i, fetch_en); end
            checks++; if (fetch_pc !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, fetch_pc, 32'(4 * i)); end
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; branch_pc = 32'h100;
        step();
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL flush1_en got %b exp 0", fetch_en); end
        branch_pc = 32'h200;
        step();
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL flush2_en got %b exp 0", fetch_en); end
        flush = 1'b0;
        step();
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL redirect_en got %b exp 1", fetch_en); end
        checks++; if (fetch_pc !== 32'h200) begin errors++; $display("FAIL redirect_pc got %h exp 200", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'h204) begin errors++; $display("FAIL redirect_next got %h exp 204", fetch_pc); end
    endtask

    task automatic test_rdy_hold();
        rdy = 1'b0;
        step();
        step();
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL rdy_hold_en got %b exp 1", fetch_en); end
        checks++; if (fetch_pc !== 32'h204) begin errors++; $display("FAIL rdy_hold_pc got %h exp 204", fetch_pc); end
        rdy = 1'b1;
        step();
        checks++; if (fetch_pc !== 32'h208) begin errors++; $display("FAIL rdy_resume_pc got %h exp 208", fetch_pc); end
    endtask

    task automatic test_stall_flush();
        flush = 1'b1; branch_pc = 32'h300;
        step();
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL sf_flush_en got %b exp 0", fetch_en); end
        flush = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rdy = (i == 1);
            step();
            checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL sf_stall_en[%0d] got %b exp 0", i, fetch_en); end
            checks++; if (fetch_pc !== 32'h208) begin errors++; $display("FAIL sf_stall_pc[%0d] got %h exp 208", i, fetch_pc); end
        end
        rdy = 1'b1; stall = 1'b0;
        step();
        checks++; if (fetch_en !== 1'b1) begin errors++; $display("FAIL sf_issue_en got %b exp 1", fetch_en); end
        checks++; if (fetch_pc !== 32'h300) begin errors++; $display("FAIL sf_issue_pc got %h exp 300", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'h304) begin errors++; $display("FAIL sf_next_pc got %h exp 304", fetch_pc); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; branch_pc = 32'hFFFF_FFF8;
        step();
        flush = 1'b0;
        step();
        checks++; if (fetch_pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap0 got %h exp fffffff8", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap1 got %h exp fffffffc", fetch_pc); end
        step();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap2 got %h exp 0", fetch_pc); end
    endtask

    task automatic restart_from_zero();
        flush = 1'b1; branch_pc = 32'h0;
        step();
        flush = 1'b0; stall = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_train_taken();
        stall = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h8; upd_taken = 1'b1; upd_target = 32'h40;
        step();
        upd_en = 1'b0;
        restart_from_zero();
        checks++; if (fetch_pc !== 32'h8) begin errors++; $display("FAIL tt_pc got %h exp 8", fetch_pc); end
        checks++; if (pred_taken !== BTB) begin errors++; $display("FAIL tt_pt got %b exp %b", pred_taken, BTB); end
        checks++; if (pred_target !== (BTB ? 32'h40 : 32'h0)) begin errors++; $display("FAIL tt_ptgt got %h exp %h", pred_target, BTB ? 32'h40 : 32'h0); end
        step();
        checks++; if (fetch_pc !== (BTB ? 32'h40 : 32'hC)) begin errors++; $display("FAIL tt_next got %h exp %h", fetch_pc, BTB ? 32'h40 : 32'hC); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL tt_next_pt got %b exp 0", pred_taken); end
    endtask

    task automatic test_train_not_taken();
        stall = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h8; upd_taken = 1'b0; upd_target = 32'h99;
        step();
        step();
        upd_en = 1'b0;
        restart_from_zero();
        checks++; if (fetch_pc !== 32'h8) begin errors++; $display("FAIL nt_pc got %h exp 8", fetch_pc); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt_pt got %b exp 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL nt_ptgt got %h exp 0", pred_target); end
        step();
        checks++; if (fetch_pc !== 32'hC) begin errors++; $display("FAIL nt_next got %h exp c", fetch_pc); end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fetch_en !== 1'b0) begin errors++; $display("FAIL areset_en got %b exp 0", fetch_en); end
        checks++; if (fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL areset_pc got %h exp fffffffc", fetch_pc); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL areset_first got %h exp 0", fetch_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flush();
        test_rdy_hold();
        test_stall_flush();
        test_wrap();
        test_train_taken();
        test_train_not_taken();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
